vx_perf_memsys_counters: RTL

Producer end of the memory-system performance interface. It counts per-cycle event pulses from the icache, dcache, shared memory and external memory port into wrapping `PERF_CTR_BITS` counters. It also accumulates outstanding-read cycles as memory latency. It drives `VX_perf_memsys_if.master` and is instantiated once per core next to the cache hierarchy when `PERF_ENABLE` is defined.

---
 rtl/vx_perf_pkg.sv | 19 +
 rtl/VX_perf_memsys_if.sv | 20 ++
 rtl/vx_perf_event_ctr.sv | 37 +++
 rtl/vx_perf_memsys_counters.sv | 77 +++++++
 4 files changed

// File: rtl/vx_perf_pkg.sv
// Shared definitions for the memory-system performance counters: counter width,
// event indices and the popcount-width helper.
package vx_perf_pkg;
  localparam int PERF_CTR_BITS = 44;

  typedef enum logic [3:0] {
    EV_ICACHE_READS, EV_ICACHE_READ_MISSES,
    EV_DCACHE_READS, EV_DCACHE_WRITES, EV_DCACHE_READ_MISSES, EV_DCACHE_WRITE_MISSES,
    EV_DCACHE_BANK_STALLS, EV_DCACHE_MSHR_STALLS,
    EV_SMEM_READS, EV_SMEM_WRITES, EV_SMEM_BANK_STALLS,
    EV_MEM_READS, EV_MEM_WRITES, EV_MEM_LATENCY
  } perf_event_e;

  localparam int NUM_PERF_EVENTS = 14;

  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/VX_perf_memsys_if.sv
// Memory-system performance counter bundle; the producer drives the master side.
interface VX_perf_memsys_if;
  import vx_perf_pkg::*;
  logic [PERF_CTR_BITS-1:0] icache_reads, icache_read_misses;
  logic [PERF_CTR_BITS-1:0] dcache_reads, dcache_writes, dcache_read_misses, dcache_write_misses;
  logic [PERF_CTR_BITS-1:0] dcache_bank_stalls, dcache_mshr_stalls;
  logic [PERF_CTR_BITS-1:0] smem_reads, smem_writes, smem_bank_stalls;
  logic [PERF_CTR_BITS-1:0] mem_reads, mem_writes, mem_latency;

  modport master (
    output icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls, dcache_mshr_stalls,
           smem_reads, smem_writes, smem_bank_stalls, mem_reads, mem_writes, mem_latency
  );
  modport slave (
    input  icache_reads, icache_read_misses, dcache_reads, dcache_writes,
           dcache_read_misses, dcache_write_misses, dcache_bank_stalls, dcache_mshr_stalls,
           smem_reads, smem_writes, smem_bank_stalls, mem_reads, mem_writes, mem_latency
  );
endinterface

// File: rtl/vx_perf_event_ctr.sv
// One event counter: registered popcount of the event mask, then a wrapping accumulator.
module vx_perf_event_ctr
  import vx_perf_pkg::*;
#(
  parameter int N = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [N-1:0]             mask,
  output logic [PERF_CTR_BITS-1:0] count
);
  localparam int PW = pc_width(N);

  logic [PW-1:0]            pc_d, pc_q;
  logic [PERF_CTR_BITS-1:0] cnt_d, cnt_q;

  // clear also drops the popcount already in flight
  always_comb begin
    pc_d = '0;
    for (int i = 0; i < N; i++) pc_d = pc_d + PW'(mask[i]);
    if (clear) pc_d = '0;
    cnt_d = clear ? '0 : cnt_q + PERF_CTR_BITS'(pc_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
endmodule

// File: rtl/vx_perf_memsys_counters.sv
// Memory-system performance counter producer: 13 event counters plus the
// outstanding-read tracker and its latency accumulator.
module vx_perf_memsys_counters
  import vx_perf_pkg::*;
#(
  parameter int DCACHE_NUM_REQS  = 4,
  parameter int DCACHE_NUM_BANKS = 4,
  parameter int SMEM_NUM_REQS    = 4,
  parameter int PENDING_BITS     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        icache_rd,
  input  logic                        icache_rd_miss,
  input  logic [DCACHE_NUM_REQS-1:0]  dcache_rd,
  input  logic [DCACHE_NUM_REQS-1:0]  dcache_wr,
  input  logic [DCACHE_NUM_BANKS-1:0] dcache_rd_miss,
  input  logic [DCACHE_NUM_BANKS-1:0] dcache_wr_miss,
  input  logic [DCACHE_NUM_REQS-1:0]  dcache_bank_stall,
  input  logic [DCACHE_NUM_BANKS-1:0] dcache_mshr_stall,
  input  logic [SMEM_NUM_REQS-1:0]    smem_rd,
  input  logic [SMEM_NUM_REQS-1:0]    smem_wr,
  input  logic [SMEM_NUM_REQS-1:0]    smem_bank_stall,
  input  logic                        mem_req_fire,
  input  logic                        mem_req_rw,
  input  logic                        mem_rsp_fire,
  VX_perf_memsys_if.master            perf_memsys_if
);
  logic rd_fire, wr_fire;
  assign rd_fire = mem_req_fire & ~mem_req_rw;
  assign wr_fire = mem_req_fire & mem_req_rw;

  vx_perf_event_ctr #(.N(1)) u_icache_reads (.clk, .reset, .clear, .mask(icache_rd), .count(perf_memsys_if.icache_reads));
  vx_perf_event_ctr #(.N(1)) u_icache_read_misses (.clk, .reset, .clear, .mask(icache_rd_miss), .count(perf_memsys_if.icache_read_misses));
  vx_perf_event_ctr #(.N(DCACHE_NUM_REQS)) u_dcache_reads (.clk, .reset, .clear, .mask(dcache_rd), .count(perf_memsys_if.dcache_reads));
  vx_perf_event_ctr #(.N(DCACHE_NUM_REQS)) u_dcache_writes (.clk, .reset, .clear, .mask(dcache_wr), .count(perf_memsys_if.dcache_writes));
  vx_perf_event_ctr #(.N(DCACHE_NUM_BANKS)) u_dcache_read_misses (.clk, .reset, .clear, .mask(dcache_rd_miss), .count(perf_memsys_if.dcache_read_misses));
  vx_perf_event_ctr #(.N(DCACHE_NUM_BANKS)) u_dcache_write_misses (.clk, .reset, .clear, .mask(dcache_wr_miss), .count(perf_memsys_if.dcache_write_misses));
  vx_perf_event_ctr #(.N(DCACHE_NUM_REQS)) u_dcache_bank_stalls (.clk, .reset, .clear, .mask(dcache_bank_stall), .count(perf_memsys_if.dcache_bank_stalls));
  vx_perf_event_ctr #(.N(DCACHE_NUM_BANKS)) u_dcache_mshr_stalls (.clk, .reset, .clear, .mask(dcache_mshr_stall), .count(perf_memsys_if.dcache_mshr_stalls));
  vx_perf_event_ctr #(.N(SMEM_NUM_REQS)) u_smem_reads (.clk, .reset, .clear, .mask(smem_rd), .count(perf_memsys_if.smem_reads));
  vx_perf_event_ctr #(.N(SMEM_NUM_REQS)) u_smem_writes (.clk, .reset, .clear, .mask(smem_wr), .count(perf_memsys_if.smem_writes));
  vx_perf_event_ctr #(.N(SMEM_NUM_REQS)) u_smem_bank_stalls (.clk, .reset, .clear, .mask(smem_bank_stall), .count(perf_memsys_if.smem_bank_stalls));
  vx_perf_event_ctr #(.N(1)) u_mem_reads (.clk, .reset, .clear, .mask(rd_fire), .count(perf_memsys_if.mem_reads));
  vx_perf_event_ctr #(.N(1)) u_mem_writes (.clk, .reset, .clear, .mask(wr_fire), .count(perf_memsys_if.mem_writes));

  logic [PENDING_BITS-1:0]  pending_d, pending_q;
  logic [PERF_CTR_BITS-1:0] lat_d, lat_q;

  // pending survives clear: those reads are still outstanding in the memory system
  always_comb begin
    pending_d = pending_q;
    if (rd_fire && !mem_rsp_fire && pending_q != '1)
      pending_d = pending_q + 1'b1;
    else if (mem_rsp_fire && !rd_fire && pending_q != '0)
      pending_d = pending_q - 1'b1;
    lat_d = clear ? '0 : lat_q + PERF_CTR_BITS'(pending_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      lat_q     <= '0;
    end else begin
      pending_q <= pending_d;
      lat_q     <= lat_d;
    end
  end

  assign perf_memsys_if.mem_latency = lat_q;

  a_pending_underflow: assert property (@(posedge clk) disable iff (reset)
    !(mem_rsp_fire && !rd_fire && pending_q == '0));
  a_pending_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rd_fire && !mem_rsp_fire && pending_q == '1));
endmodule
